onehot_decoder_hold: RTL and testbench



---
 rtl/onehot_decoder_hold.sv | 142 ++++++++++++++
 tb/tb_onehot_decoder_hold.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_hold.sv
// Registered 3-to-8 decoder: each accepted code drives its one-hot line for HOLD
// cycles, then a single all-zero gap cycle; a one-entry buffer absorbs a code sent early.
module onehot_decoder_hold #(
  parameter int HOLD = 4,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic valid,
  output logic ready,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic h,
  output logic busy,
  output logic done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  if (HOLD < 1 || HOLD > (1 << CW)) begin : g_hold_check
    $error("onehot_decoder_hold: HOLD must be in 1..2**CW");
  end

  logic [1:0]    r_state;
  logic [2:0]    r_cur;
  logic [2:0]    r_pend;
  logic          r_pend_valid;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_lines;
  logic          r_done;

  logic [2:0]    w_code;
  logic          w_ready;
  logic          w_accept;
  logic [1:0]    w_state_next;
  logic [2:0]    w_cur_next;
  logic [2:0]    w_pend_next;
  logic          w_pend_valid_next;
  logic [CW-1:0] w_cnt_next;
  logic [7:0]    w_lines_next;

  assign w_code   = {in2, in1, in0};
  // ready depends on registers only, so valid never reaches ready combinationally
  assign w_ready  = (r_state == S_IDLE) || !r_pend_valid;
  assign w_accept = valid && w_ready;

  always_comb begin
    w_state_next      = r_state;
    w_cur_next        = r_cur;
    w_pend_next       = r_pend;
    w_pend_valid_next = r_pend_valid;
    w_cnt_next        = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cur_next   = w_code;
          w_cnt_next   = HOLD_M1;
          w_state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_next = S_GAP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
        if (w_accept) begin
          w_pend_next       = w_code;
          w_pend_valid_next = 1'b1;
        end
      end
      S_GAP: begin
        if (r_pend_valid) begin
          w_cur_next        = r_pend;
          w_pend_valid_next = 1'b0;
          w_cnt_next        = HOLD_M1;
          w_state_next      = S_DRIVE;
        end else if (w_accept) begin
          w_cur_next   = w_code;
          w_cnt_next   = HOLD_M1;
          w_state_next = S_DRIVE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Lines are decoded from the next state so the registered outputs line up with it
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_dec
    assign w_lines_next[gi] = (w_state_next == S_DRIVE) && (w_cur_next == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= 3'd0;
      r_pend       <= 3'd0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_lines      <= 8'h00;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cur        <= w_cur_next;
      r_pend       <= w_pend_next;
      r_pend_valid <= w_pend_valid_next;
      r_cnt        <= w_cnt_next;
      r_lines      <= w_lines_next;
      r_done       <= (w_state_next == S_GAP);
    end
  end

  assign ready = w_ready;
  assign busy  = (r_state != S_IDLE) || r_pend_valid;
  assign done  = r_done;
  assign a     = r_lines[0];
  assign b     = r_lines[1];
  assign c     = r_lines[2];
  assign d     = r_lines[3];
  assign e     = r_lines[4];
  assign f     = r_lines[5];
  assign g     = r_lines[6];
  assign h     = r_lines[7];

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Directed bench for onehot_decoder_hold: HOLD=4 instance for most scenarios,
// HOLD=1 instance for the fast sweep.
module tb_onehot_decoder_hold;

  logic clk;
  logic rst;
  logic [2:0] code;
  logic valid;
  logic ready, a, b, c, d, e, f, g, h, busy, done;
  logic [7:0] lines;

  logic [2:0] h1_code;
  logic h1_valid;
  logic h1_ready, h1_a, h1_b, h1_c, h1_d, h1_e, h1_f, h1_g, h1_h, h1_busy, h1_done;
  logic [7:0] h1_lines;

  int tests_run;
  int tests_failed;

  onehot_decoder_hold #(.HOLD(4), .CW(3)) u_dut (
    .clk(clk), .rst(rst),
    .in0(code[0]), .in1(code[1]), .in2(code[2]),
    .valid(valid), .ready(ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .busy(busy), .done(done)
  );

  onehot_decoder_hold #(.HOLD(1), .CW(3)) u_h1 (
    .clk(clk), .rst(rst),
    .in0(h1_code[0]), .in1(h1_code[1]), .in2(h1_code[2]),
    .valid(h1_valid), .ready(h1_ready),
    .a(h1_a), .b(h1_b), .c(h1_c), .d(h1_d), .e(h1_e), .f(h1_f), .g(h1_g), .h(h1_h),
    .busy(h1_busy), .done(h1_done)
  );

  assign lines    = {h, g, f, e, d, c, b, a};
  assign h1_lines = {h1_h, h1_g, h1_f, h1_e, h1_d, h1_c, h1_b, h1_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (lines !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: lines=%b busy=%b done=%b ready=%b, expected 00000000 0 0 1",
               lines, busy, done, ready);
    end
    tests_run++;
    if (h1_lines !== 8'h00 || h1_busy !== 1'b0 || h1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_h1: lines=%b busy=%b ready=%b, expected 00000000 0 1",
               h1_lines, h1_busy, h1_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_single(input logic [2:0] cin);
    logic [7:0] exp;
    exp   = 8'b0000_0001 << cin;
    code  = cin;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lines !== exp || done !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_%0d drive cycle %0d: lines=%b done=%b busy=%b, expected %b 0 1",
                 cin, i, lines, done, busy, exp);
      end
      tick();
    end
    tests_run++;
    if (lines !== 8'h00 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_%0d gap: lines=%b done=%b, expected 00000000 1", cin, lines, done);
    end
    tick();
    tests_run++;
    if (lines !== 8'h00 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_%0d idle: lines=%b done=%b busy=%b ready=%b, expected 00000000 0 0 1",
               cin, lines, done, busy, ready);
    end
    $display("[TB] single code %b checked", cin);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [11];
    int dones;
    for (int i = 0; i < 11; i++) exp_seq[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_seq[i]     = 8'b0010_0000;
      exp_seq[i + 5] = 8'b0000_0100;
    end
    dones = 0;
    code  = 3'b101;
    valid = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      tests_run++;
      if (lines !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL b2b cycle %0d: lines=%b expected %b", i, lines, exp_seq[i]);
      end
      if (done === 1'b1) dones++;
      if (i == 1 || i == 4) begin
        tests_run++;
        if (ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b ready_pending cycle %0d: ready=%b expected 0", i, ready);
        end
      end
      if (i == 5) begin
        tests_run++;
        if (ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b ready_return: ready=%b expected 1", ready);
        end
      end
      if (i == 0) begin
        code  = 3'b010;
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      tick();
    end
    tests_run++;
    if (dones != 2) begin
      tests_failed++;
      $display("FAIL b2b done_count: got %0d expected 2", dones);
    end
    $display("[TB] back-to-back 101 then 010 checked");
  endtask

  task automatic test_backpressure();
    logic [2:0] codes [3];
    logic [7:0] exp_seq [16];
    int k;
    int acc_cycle2;
    logic acc;
    codes[0] = 3'b001;
    codes[1] = 3'b011;
    codes[2] = 3'b110;
    for (int i = 0; i < 16; i++) exp_seq[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_seq[i]      = 8'b0000_0010;
      exp_seq[i + 5]  = 8'b0000_1000;
      exp_seq[i + 10] = 8'b0100_0000;
    end
    k          = 0;
    acc_cycle2 = -1;
    code       = codes[0];
    valid      = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        tests_run++;
        if (lines !== exp_seq[i - 1] || !$onehot0(lines)) begin
          tests_failed++;
          $display("FAIL backpressure cycle %0d: lines=%b expected %b", i, lines, exp_seq[i - 1]);
        end
      end
      acc = valid && ready;
      if (acc && k == 2) acc_cycle2 = i;
      tick();
      if (acc) begin
        k++;
        if (k < 3) code = codes[k];
        else valid = 1'b0;
      end
    end
    tests_run++;
    if (k != 3 || acc_cycle2 != 6) begin
      tests_failed++;
      $display("FAIL backpressure accepts: count=%0d third_at=%0d expected 3 and 6", k, acc_cycle2);
    end
    $display("[TB] backpressure 001,011,110 checked");
  endtask

  task automatic test_mid_reset();
    int bad;
    code  = 3'b100;
    valid = 1'b1;
    tick();
    code  = 3'b011;
    tick();
    valid = 1'b0;
    tests_run++;
    if (lines !== 8'b0001_0000 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset pre: lines=%b ready=%b expected 00010000 0", lines, ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (lines !== 8'h00 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset post: lines=%b done=%b busy=%b ready=%b expected 00000000 0 0 1",
               lines, done, busy, ready);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lines !== 8'h00 || done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mid_reset quiet: %0d cycles with activity, expected 0", bad);
    end
    $display("[TB] mid-operation reset checked");
  endtask

  task automatic test_hold1_sweep();
    logic [7:0] exp;
    int k;
    int dones;
    logic acc;
    k        = 0;
    dones    = 0;
    h1_code  = 3'd0;
    h1_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) begin
        if (i % 2 == 1 && i <= 15) exp = 8'b0000_0001 << ((i - 1) / 2);
        else exp = 8'h00;
        tests_run++;
        if (h1_lines !== exp || !$onehot0(h1_lines)) begin
          tests_failed++;
          $display("FAIL hold1 cycle %0d: lines=%b expected %b", i, h1_lines, exp);
        end
        if (h1_done === 1'b1) dones++;
      end
      acc = h1_valid && h1_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 8) h1_code = 3'(k);
        else h1_valid = 1'b0;
      end
    end
    tests_run++;
    if (dones != 8 || k != 8) begin
      tests_failed++;
      $display("FAIL hold1 counts: done=%0d accepts=%0d expected 8 8", dones, k);
    end
    $display("[TB] HOLD=1 sweep checked");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    code     = 3'd0;
    valid    = 1'b0;
    h1_code  = 3'd0;
    h1_valid = 1'b0;
    test_reset();
    test_single(3'b000);
    test_single(3'b101);
    test_single(3'b111);
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_hold1_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
